i2c_arbiter: RTL and testbench

//  Shares one i2c_basic controller between NUM_REQ requesters (codec/PLL/PMIC config engines).

---
 rtl/i2c_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c controller among NUM_REQ
// config engines, with start/done sequencing and a hang watchdog.
module i2c_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [7*NUM_REQ-1:0]  req_addr,
  input  logic [2*NUM_REQ-1:0]  req_num_wr,
  input  logic [24*NUM_REQ-1:0] req_wr_data,
  input  logic [2*NUM_REQ-1:0]  req_num_rd,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_rd_data,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [6:0]            i2c_addr,
  output logic [1:0]            i2c_num_wr_bytes,
  output logic [7:0]            i2c_wr_data0,
  output logic [7:0]            i2c_wr_data1,
  output logic [7:0]            i2c_wr_data2,
  output logic [1:0]            i2c_num_rd_bytes,
  output logic                  i2c_start,
  input  logic                  i2c_done,
  input  logic [7:0]            i2c_rd_data0,
  input  logic [7:0]            i2c_rd_data1,
  output logic                  i2c_reset
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
  } state_t;

  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);

  state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] own_q, own_d;
  logic busy_q, busy_d;
  logic err_q, err_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d;
  logic [15:0] rd_q, rd_d;
  logic rerr_q, rerr_d;
  logic [6:0] addr_q, addr_d;
  logic [1:0] nwr_q, nwr_d;
  logic [1:0] nrd_q, nrd_d;
  logic [23:0] data_q, data_d;
  logic start_q, start_d;
  logic irst_q, irst_d;
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;

  logic found;
  logic [2:0] win;
  logic [NUM_REQ-1:0] gnt;
  logic [6:0] w_addr;
  logic [1:0] w_nwr;
  logic [1:0] w_nrd;
  logic [23:0] w_data;

  // first valid requester at or after the pointer, wrapping around
  always_comb begin
    found = 1'b0;
    win   = '0;
    gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(ptr_q) + k == i) ||
             (int'(ptr_q) + k == i + NUM_REQ))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          win    = 3'(i);
        end
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_nwr  = '0;
    w_nrd  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_addr = req_addr[7*i +: 7];
        w_nwr  = req_num_wr[2*i +: 2];
        w_nrd  = req_num_rd[2*i +: 2];
        w_data = req_wr_data[24*i +: 24];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    busy_d  = busy_q;
    err_d   = err_q;
    rdy_d   = '0;
    rsp_d   = '0;
    rd_d    = rd_q;
    rerr_d  = rerr_q;
    addr_d  = addr_q;
    nwr_d   = nwr_q;
    nrd_d   = nrd_q;
    data_d  = data_q;
    start_d = 1'b0;
    irst_d  = 1'b0;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (found && i2c_done) begin
          rdy_d  = gnt;
          busy_d = 1'b1;
          own_d  = win;
          addr_d = w_addr;
          nwr_d  = w_nwr;
          data_d = w_data;
          if (w_nwr != 2'd0)
            nrd_d = 2'd0;
          else if (w_nrd == 2'd3)
            nrd_d = 2'd2;
          else
            nrd_d = w_nrd;
          err_d   = (w_nwr == 2'd0) && (w_nrd == 2'd0);
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        wdog_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!i2c_done) begin
          wdog_d  = '0;
          state_d = WAIT_DONE;
        end else if (&wdog_q) begin
          irst_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i2c_done) begin
          rd_d    = {i2c_rd_data1, i2c_rd_data0};
          state_d = RESP;
        end else if (&wdog_q) begin
          irst_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++)
          rsp_d[i] = (own_q == 3'(i));
        rerr_d  = err_q;
        busy_d  = 1'b0;
        ptr_d   = (own_q == LAST) ? 3'd0 : own_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= '0;
      rsp_q   <= '0;
      rd_q    <= '0;
      rerr_q  <= 1'b0;
      addr_q  <= '0;
      nwr_q   <= '0;
      nrd_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      irst_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      rsp_q   <= rsp_d;
      rd_q    <= rd_d;
      rerr_q  <= rerr_d;
      addr_q  <= addr_d;
      nwr_q   <= nwr_d;
      nrd_q   <= nrd_d;
      data_q  <= data_d;
      start_q <= start_d;
      irst_q  <= irst_d;
      wdog_q  <= wdog_d;
    end
  end

  assign req_ready        = rdy_q;
  assign rsp_valid        = rsp_q;
  assign rsp_rd_data      = rd_q;
  assign rsp_error        = rerr_q;
  assign busy             = busy_q;
  assign grant_id         = own_q;
  assign i2c_addr         = addr_q;
  assign i2c_num_wr_bytes = nwr_q;
  assign i2c_wr_data0     = data_q[7:0];
  assign i2c_wr_data1     = data_q[15:8];
  assign i2c_wr_data2     = data_q[23:16];
  assign i2c_num_rd_bytes = nrd_q;
  assign i2c_start        = start_q;
  assign i2c_reset        = irst_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed stimulus with queued expectations checked by
// negedge monitors against a simple behavioural i2c controller.
module tb_i2c_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [2*N-1:0] req_num_wr = '0;
  logic [24*N-1:0] req_wr_data = '0;
  logic [2*N-1:0] req_num_rd = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [15:0] rsp_rd_data;
  logic rsp_error, busy;
  logic [2:0] grant_id;
  logic [6:0] i2c_addr;
  logic [1:0] i2c_num_wr_bytes, i2c_num_rd_bytes;
  logic [7:0] i2c_wr_data0, i2c_wr_data1, i2c_wr_data2;
  logic i2c_start, i2c_reset;
  logic [7:0] m_rd0 = 8'h00;
  logic [7:0] m_rd1 = 8'h00;
  logic m_done = 1'b1;
  int m_cnt = 0;
  int m_lat = 0;
  bit hang = 1'b0;

  always #5 clk = ~clk;

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_num_wr(req_num_wr), .req_wr_data(req_wr_data),
    .req_num_rd(req_num_rd), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .rsp_error(rsp_error), .busy(busy), .grant_id(grant_id),
    .i2c_addr(i2c_addr), .i2c_num_wr_bytes(i2c_num_wr_bytes),
    .i2c_wr_data0(i2c_wr_data0), .i2c_wr_data1(i2c_wr_data1),
    .i2c_wr_data2(i2c_wr_data2), .i2c_num_rd_bytes(i2c_num_rd_bytes),
    .i2c_start(i2c_start), .i2c_done(m_done),
    .i2c_rd_data0(m_rd0), .i2c_rd_data1(m_rd1),
    .i2c_reset(i2c_reset)
  );

  // controller model: done drops after start, returns m_lat cycles later
  always @(posedge clk) begin
    if (i2c_reset) begin
      m_done <= 1'b1;
      m_cnt  <= 0;
    end else if (i2c_start && !hang) begin
      m_done <= 1'b0;
      m_cnt  <= m_lat;
    end else if (!m_done) begin
      if (m_cnt == 0) m_done <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  typedef struct packed {
    logic [6:0] a; logic [1:0] nw; logic [23:0] d; logic [1:0] nr;
  } st_t;
  typedef struct packed {
    logic [N-1:0] oh; logic [15:0] rd; logic err;
  } rsp_t;

  int rdy_q[$];
  st_t st_q[$];
  rsp_t rsp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rdy = 0;
  int last_start = 0;
  int exp_tmo = 0;
  bit rn_q = 1'b0;
  bit rr_pend = 1'b0;
  logic [6:0] rr_addr = '0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rn_q <= reset_n;
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rn_q) begin
      if (|req_ready) begin
        last_rdy = cyc;
        if (rdy_q.size() == 0) begin
          chk("ready_unexpected", {grant_id, req_ready}, 0);
        end else begin
          int e;
          logic [N-1:0] oh;
          e = rdy_q.pop_front();
          oh = '0;
          oh[e] = 1'b1;
          chk("ready_grant", {grant_id, req_ready}, {3'(e), oh});
          chk("busy_at_ready", busy, 1);
        end
      end
      if (i2c_start) begin
        last_start = cyc;
        if (st_q.size() == 0) begin
          chk("start_unexpected", i2c_start, 0);
        end else begin
          st_t s;
          s = st_q.pop_front();
          chk("start_payload",
              {i2c_addr, i2c_num_wr_bytes, i2c_wr_data2,
               i2c_wr_data1, i2c_wr_data0, i2c_num_rd_bytes}, s);
          chk("start_latency", cyc - last_rdy, 1);
        end
      end
      if (i2c_reset) begin
        chk("tmo_expected", exp_tmo > 0, 1);
        if (exp_tmo > 0) exp_tmo--;
        chk("tmo_delay", cyc - last_start, 16);
      end
      if (|rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp", {rsp_valid, rsp_rd_data, rsp_error}, r);
          chk("busy_at_rsp", busy, 0);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [6:0] a,
                         input logic [1:0] nw, input logic [23:0] d,
                         input logic [1:0] nr);
    req_addr[7*i +: 7]     = a;
    req_num_wr[2*i +: 2]   = nw;
    req_wr_data[24*i +: 24] = d;
    req_num_rd[2*i +: 2]   = nr;
    req_valid[i]           = 1'b1;
  endtask

  task automatic exp_txn(input int i, input logic [6:0] a,
                         input logic [1:0] nw, input logic [23:0] d,
                         input logic [1:0] enr, input bit legal,
                         input logic err, input logic [15:0] rd);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    rdy_q.push_back(i);
    if (legal) st_q.push_back({a, nw, d, enr});
    rsp_q.push_back({oh, rd, err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (i == 0 && rr_pend) begin
          req_addr[6:0] = rr_addr;
          rr_pend = 1'b0;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_idle(input string nm, input int max);
    for (int n = 0; n < max; n++) begin
      step();
      if (req_valid == '0 && !busy && rdy_q.size() == 0 &&
          st_q.size() == 0 && rsp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s budget expired got=busy exp=idle", nm);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_pulses"}, {req_ready, rsp_valid, busy, rsp_error, i2c_start}, 0);
    chk({nm, "_rd"}, rsp_rd_data, 0);
    chk({nm, "_gid"}, grant_id, 0);
    chk({nm, "_i2c"}, {i2c_addr, i2c_num_wr_bytes, i2c_wr_data2,
                       i2c_wr_data1, i2c_wr_data0, i2c_num_rd_bytes}, 0);
    chk({nm, "_i2c_reset"}, i2c_reset, 1);
  endtask

  initial begin
    step();
    step();
    @(negedge clk);
    check_reset("rst_init");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // single write from req0
    m_rd0 = 8'h11; m_rd1 = 8'h22; m_lat = 0;
    set_req(0, 7'h1A, 2'd2, 24'h003412, 2'd0);
    exp_txn(0, 7'h1A, 2'd2, 24'h003412, 2'd0, 1, 0, 16'h2211);
    run_idle("t1", 40);

    // req3 moves the pointer back to 0
    set_req(3, 7'h1F, 2'd1, 24'h000055, 2'd0);
    exp_txn(3, 7'h1F, 2'd1, 24'h000055, 2'd0, 1, 0, 16'h2211);
    run_idle("t1b", 40);

    // four at once, req0 re-raised after its grant
    set_req(0, 7'h10, 2'd1, 24'h000001, 2'd0);
    set_req(1, 7'h11, 2'd1, 24'h000002, 2'd0);
    set_req(2, 7'h12, 2'd1, 24'h000003, 2'd0);
    set_req(3, 7'h13, 2'd1, 24'h000004, 2'd0);
    rr_addr = 7'h14;
    rr_pend = 1'b1;
    exp_txn(0, 7'h10, 2'd1, 24'h000001, 2'd0, 1, 0, 16'h2211);
    exp_txn(1, 7'h11, 2'd1, 24'h000002, 2'd0, 1, 0, 16'h2211);
    exp_txn(2, 7'h12, 2'd1, 24'h000003, 2'd0, 1, 0, 16'h2211);
    exp_txn(3, 7'h13, 2'd1, 24'h000004, 2'd0, 1, 0, 16'h2211);
    exp_txn(0, 7'h14, 2'd1, 24'h000001, 2'd0, 1, 0, 16'h2211);
    run_idle("t2", 200);

    // read from req2; req1 raises and withdraws while busy
    m_rd0 = 8'hA5; m_rd1 = 8'h3C; m_lat = 3;
    set_req(2, 7'h50, 2'd0, 24'h0, 2'd2);
    exp_txn(2, 7'h50, 2'd0, 24'h0, 2'd2, 1, 0, 16'h3CA5);
    step();
    step();
    set_req(1, 7'h33, 2'd1, 24'h000099, 2'd0);
    step();
    step();
    req_valid[1] = 1'b0;
    run_idle("t3", 60);

    // num_rd=3 clamps to 2
    set_req(1, 7'h51, 2'd0, 24'h0, 2'd3);
    exp_txn(1, 7'h51, 2'd0, 24'h0, 2'd2, 1, 0, 16'h3CA5);
    run_idle("t3b", 60);

    // write takes precedence over read
    m_rd0 = 8'h5A; m_rd1 = 8'hC3;
    set_req(3, 7'h52, 2'd1, 24'h0000AB, 2'd2);
    exp_txn(3, 7'h52, 2'd1, 24'h0000AB, 2'd0, 1, 0, 16'hC35A);
    run_idle("t3c", 60);

    // illegal request: error, no start, read data held
    set_req(1, 7'h40, 2'd0, 24'h0, 2'd0);
    exp_txn(1, 7'h40, 2'd0, 24'h0, 2'd0, 0, 1, 16'hC35A);
    run_idle("t5", 40);

    // hung controller: watchdog timeout, then next request served
    hang = 1'b1;
    exp_tmo = 1;
    set_req(0, 7'h60, 2'd1, 24'h000077, 2'd0);
    exp_txn(0, 7'h60, 2'd1, 24'h000077, 2'd0, 1, 1, 16'hC35A);
    run_idle("t4", 80);
    hang = 1'b0;
    chk("tmo_seen", exp_tmo, 0);
    m_rd0 = 8'h01; m_rd1 = 8'h02; m_lat = 0;
    set_req(3, 7'h61, 2'd1, 24'h000088, 2'd0);
    exp_txn(3, 7'h61, 2'd1, 24'h000088, 2'd0, 1, 0, 16'h0201);
    run_idle("t4b", 40);

    // reset while waiting for done drops the transaction silently
    m_lat = 10;
    set_req(0, 7'h70, 2'd1, 24'h0000EE, 2'd0);
    rdy_q.push_back(0);
    st_q.push_back({7'h70, 2'd1, 24'h0000EE, 2'd0});
    for (int n = 0; n < 20 && m_done; n++) step();
    step();
    step();
    chk("t6_busy", busy, 1);
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check_reset("rst_mid");
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("t6_queues", rdy_q.size() + st_q.size(), 0);
    m_lat = 0;
    set_req(0, 7'h71, 2'd1, 24'h000042, 2'd0);
    exp_txn(0, 7'h71, 2'd1, 24'h000042, 2'd0, 1, 0, 16'h0201);
    run_idle("t6b", 40);

    repeat (3) step();
    chk("end_queues", rdy_q.size() + st_q.size() + rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
